// File: rtl/dmem_copy_engine.sv
// Block-copy master for the RISC16 data memory: READ/WRITE ping-pong, one word per two cycles.
// Optional running checksum of copied words when DMEM_COPY_CHECKSUM_EN is defined.
module dmem_copy_engine #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_access_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_en,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data
`ifdef DMEM_COPY_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic [LEN_W-1:0]  count;
    logic [DATA_W-1:0] hold;
    logic              accept;
    logic              last_word;

    assign accept    = (state == IDLE) && start;
    assign last_word = (count == LEN_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (length != '0) ? READ : DONE;
                end
            end
            READ:  state_nxt = WRITE;
            WRITE: state_nxt = last_word ? DONE : READ;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pointers wrap naturally at 2^ADDR_W; the memory itself aliases every 8 words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_ptr <= '0;
            dst_ptr <= '0;
            count   <= '0;
            hold    <= '0;
        end else begin
            if (accept) begin
                src_ptr <= src_addr;
                dst_ptr <= dst_addr;
                count   <= length;
            end else if (state == READ) begin
                hold <= mem_read_data;
            end else if (state == WRITE) begin
                src_ptr <= src_ptr + 1'b1;
                dst_ptr <= dst_ptr + 1'b1;
                count   <= count - 1'b1;
            end
        end
    end

`ifdef DMEM_COPY_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= '0;
        end else if (state == READ) begin
            checksum <= checksum + mem_read_data;
        end
    end
`endif

    // Memory-side outputs depend on state only, so an async reset drops the strobe at once.
    always_comb begin
        busy            = 1'b0;
        done            = 1'b0;
        mem_access_addr = '0;
        mem_write_data  = '0;
        mem_write_en    = 1'b0;
        mem_read        = 1'b0;
        case (state)
            READ: begin
                busy            = 1'b1;
                mem_access_addr = src_ptr;
                mem_read        = 1'b1;
            end
            WRITE: begin
                busy            = 1'b1;
                mem_access_addr = dst_ptr;
                mem_write_data  = hold;
                mem_write_en    = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule
